data_mem_lsu: RTL and testbench

Parametrised data-memory load/store unit, the successor of the fixed 32-bit byte-lane data memory. It accepts byte-addressed load/store requests over a valid/ready handshake and derives lane enables from address and size. Loads are sign- or zero-extended; misaligned or illegal accesses are flagged. The block has a registered 2-cycle response path and keeps the combinational debug/display read port used by the board display logic.

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/data_mem_lsu_if.sv | 35 +++
 rtl/mem_byte_bank.sv | 32 +++
 rtl/data_mem_lsu.sv | 133 +++++++++++++
 tb/tb_data_mem_lsu.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the data-memory load/store unit.
// Lane masks are 8 bits wide; 32-bit builds use the low four.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    function automatic logic [7:0] lane_mask(
        input logic [1:0] size,
        input logic [2:0] off
    );
        logic [7:0] base;
        unique case (size)
            SZ_B:    base = 8'h01;
            SZ_H:    base = 8'h03;
            SZ_W:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << off;
    endfunction

endpackage

// File: rtl/data_mem_lsu_if.sv
// Request/response and debug-read bundle of the load/store unit.
// The slave side is the memory; the master side issues requests.
interface data_mem_lsu_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int DBG_ADDR_WIDTH = 4
);
    localparam int OFF_BITS = $clog2(DATA_WIDTH / 8);

    logic                           req_valid;
    logic                           req_ready;
    logic                           req_we;
    logic [1:0]                     req_size;
    logic                           req_unsigned;
    logic [ADDR_WIDTH+OFF_BITS-1:0] req_addr;
    logic [DATA_WIDTH-1:0]          req_wdata;
    logic                           rsp_valid;
    logic [DATA_WIDTH-1:0]          rsp_rdata;
    logic                           rsp_err;
    logic [DBG_ADDR_WIDTH-1:0]      dbg_addr;
    logic [DATA_WIDTH-1:0]          dbg_data;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned,
        input  req_addr, req_wdata, dbg_addr,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, dbg_data
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned,
        output req_addr, req_wdata, dbg_addr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, dbg_data
    );

endinterface

// File: rtl/mem_byte_bank.sv
// One byte lane of the data memory: write port, registered read,
// and an asynchronous debug read for the display logic.
module mem_byte_bank #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [7:0]            din_i,
    output logic [7:0]            dout_o,
    input  logic [ADDR_WIDTH-1:0] dbg_addr_i,
    output logic [7:0]            dbg_dout_o
);

    logic [7:0] mem_q [2**ADDR_WIDTH];
    logic [7:0] dout_q;

    // Array contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= din_i;
        end
        if (re_i) begin
            dout_q <= mem_q[addr_i];
        end
    end

    assign dout_o     = dout_q;
    assign dbg_dout_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/data_mem_lsu.sv
// Byte-lane data memory with a 3-state handshake FSM, alignment
// checking and sign/zero-extending loads.
module data_mem_lsu
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int DBG_ADDR_WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    data_mem_lsu_if.slave bus
);

    localparam int LANES    = DATA_WIDTH / 8;
    localparam int OFF_BITS = $clog2(LANES);
    localparam int AW       = ADDR_WIDTH + OFF_BITS;

    state_e                state_q, state_d;
    logic                  we_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic [AW-1:0]         addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  err_q;

    logic                  hs;
    logic                  err_d;
    logic [OFF_BITS-1:0]   off;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [ADDR_WIDTH-1:0] dbg_waddr;
    logic [3:0]            size_bytes;
    logic [3:0]            align_mask;
    logic [7:0]            mask8;
    logic [DATA_WIDTH-1:0] wsh;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] dbg_word;
    logic [DATA_WIDTH-1:0] sh;
    logic [DATA_WIDTH-1:0] ext;
    logic                  fill;
    int                    nbits;
    int                    sidx;
    logic                  in_access;
    logic                  in_resp;

    assign in_access = (state_q == ACCESS);
    assign in_resp   = (state_q == RESP);
    assign hs        = (state_q == IDLE) && bus.req_valid;
    assign off       = addr_q[OFF_BITS-1:0];
    assign waddr     = addr_q[AW-1:OFF_BITS];
    assign dbg_waddr = ADDR_WIDTH'(bus.dbg_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= SZ_B;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (hs) begin
                we_q    <= bus.req_we;
                size_q  <= bus.req_size;
                uns_q   <= bus.req_unsigned;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            if (in_access) begin
                err_q <= err_d;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.req_valid) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Oversized accesses and offsets not aligned to the size are errors.
    always_comb begin
        size_bytes = 4'd1 << size_q;
        align_mask = size_bytes - 4'd1;
        err_d      = (int'(size_bytes) > LANES) ||
                     ((4'(off) & align_mask) != 4'd0);
        mask8      = lane_mask(size_q, 3'(off));
        wsh        = wdata_q << {off, 3'b000};
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic lane_we;
        assign lane_we = in_access && we_q && !err_d &&
                         mask8[l] && !rst;
        mem_byte_bank #(
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_bank (
            .clk        (clk),
            .we_i       (lane_we),
            .re_i       (in_access && !we_q),
            .addr_i     (waddr),
            .din_i      (wsh[8*l +: 8]),
            .dout_o     (rd_word[8*l +: 8]),
            .dbg_addr_i (dbg_waddr),
            .dbg_dout_o (dbg_word[8*l +: 8])
        );
    end

    // Right-justify the addressed bytes, then extend above the access width.
    always_comb begin
        sh    = rd_word >> {off, 3'b000};
        nbits = 8 << size_q;
        sidx  = (nbits > DATA_WIDTH) ? DATA_WIDTH - 1 : nbits - 1;
        fill  = !uns_q && sh[sidx];
        ext   = sh;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (i >= nbits) ext[i] = fill;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = in_resp;
    assign bus.rsp_err   = in_resp && err_q;
    assign bus.rsp_rdata = (in_resp && !we_q && !err_q) ? ext : '0;
    assign bus.dbg_data  = dbg_word;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu: a 32-bit and a 64-bit build
// share clock and reset; each scenario task checks its own results.
module tb_data_mem_lsu;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    data_mem_lsu_if #(.DATA_WIDTH(32)) if32 ();
    data_mem_lsu_if #(.DATA_WIDTH(64)) if64 ();

    data_mem_lsu #(.DATA_WIDTH(32)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (if32.slave)
    );

    data_mem_lsu #(.DATA_WIDTH(64)) dut64 (
        .clk (clk),
        .rst (rst),
        .bus (if64.slave)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] r_data;
    logic        r_err;
    int          r_lat;
    logic        r_after;
    logic        r_rdy;

    task automatic clear_req();
        if32.req_valid = 1'b0;
        if64.req_valid = 1'b0;
    endtask

    // Issues one request and records response data, error, the edge
    // count from the handshake edge to rsp_valid, and rsp_valid after.
    task automatic req(input bit w64, input logic we,
                       input logic [1:0] sz, input logic uns,
                       input logic [12:0] addr, input logic [63:0] wd);
        logic rv;
        @(negedge clk);
        if (w64) begin
            if64.req_valid    = 1'b1;
            if64.req_we       = we;
            if64.req_size     = sz;
            if64.req_unsigned = uns;
            if64.req_addr     = addr;
            if64.req_wdata    = wd;
            r_rdy             = if64.req_ready;
        end else begin
            if32.req_valid    = 1'b1;
            if32.req_we       = we;
            if32.req_size     = sz;
            if32.req_unsigned = uns;
            if32.req_addr     = addr[11:0];
            if32.req_wdata    = wd[31:0];
            r_rdy             = if32.req_ready;
        end
        r_lat   = 0;
        r_data  = 64'hBAD0_BAD0_BAD0_BAD0;
        r_err   = 1'bx;
        r_after = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            clear_req();
            rv = w64 ? if64.rsp_valid : if32.rsp_valid;
            if (rv) begin
                r_lat  = k;
                r_data = w64 ? if64.rsp_rdata : {32'h0, if32.rsp_rdata};
                r_err  = w64 ? if64.rsp_err : if32.rsp_err;
                break;
            end
        end
        @(posedge clk);
        #1;
        r_after = w64 ? if64.rsp_valid : if32.rsp_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_req();
        if32.dbg_addr = '0;
        if64.dbg_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (if32.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready32 got=%b exp=1", if32.req_ready);
        end
        checks++;
        if (if32.rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_rsp_valid32 got=%b exp=0", if32.rsp_valid);
        end
        checks++;
        if (if32.rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_rsp_err32 got=%b exp=0", if32.rsp_err);
        end
        checks++;
        if (if32.rsp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_rdata32 got=%h exp=0", if32.rsp_rdata);
        end
        checks++;
        if (if64.req_ready !== 1'b1 || if64.rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_64 got=%b%b exp=10",
                     if64.req_ready, if64.rsp_valid);
        end
    endtask

    task automatic test_word();
        req(1'b0, 1'b1, SZ_W, 1'b0, 13'h10, 64'h8899AABB);
        checks++;
        if (r_rdy !== 1'b1 || r_lat !== 2 || r_after !== 1'b0) begin
            failures++;
            $display("FAIL st_word_timing got=rdy%b lat%0d after%b exp=rdy1 lat2 after0",
                     r_rdy, r_lat, r_after);
        end
        checks++;
        if (r_err !== 1'b0 || r_data !== 64'h0) begin
            failures++;
            $display("FAIL st_word_rsp got=err%b %h exp=err0 0", r_err, r_data);
        end
        req(1'b0, 1'b0, SZ_W, 1'b0, 13'h10, 64'h0);
        checks++;
        if (r_lat !== 2 || r_after !== 1'b0) begin
            failures++;
            $display("FAIL ld_word_timing got=lat%0d after%b exp=lat2 after0",
                     r_lat, r_after);
        end
        checks++;
        if (r_err !== 1'b0 || r_data !== 64'h8899AABB) begin
            failures++;
            $display("FAIL ld_word got=err%b %h exp=err0 8899aabb", r_err, r_data);
        end
    endtask

    task automatic test_byte();
        req(1'b0, 1'b1, SZ_B, 1'b0, 13'h13, 64'hF0);
        req(1'b0, 1'b0, SZ_B, 1'b0, 13'h13, 64'h0);
        checks++;
        if (r_err !== 1'b0 || r_data !== 64'hFFFFFFF0) begin
            failures++;
            $display("FAIL ld_byte_signed got=%h exp=fffffff0", r_data);
        end
        req(1'b0, 1'b0, SZ_B, 1'b1, 13'h13, 64'h0);
        checks++;
        if (r_data !== 64'h000000F0) begin
            failures++;
            $display("FAIL ld_byte_unsigned got=%h exp=000000f0", r_data);
        end
        req(1'b0, 1'b0, SZ_W, 1'b0, 13'h10, 64'h0);
        checks++;
        if (r_data !== 64'hF099AABB) begin
            failures++;
            $display("FAIL ld_word_merged got=%h exp=f099aabb", r_data);
        end
        req(1'b0, 1'b0, SZ_H, 1'b0, 13'h12, 64'h0);
        checks++;
        if (r_data !== 64'hFFFFF099) begin
            failures++;
            $display("FAIL ld_half_signed_neg got=%h exp=fffff099", r_data);
        end
    endtask

    task automatic test_half();
        req(1'b0, 1'b1, SZ_W, 1'b0, 13'h20, 64'h0);
        req(1'b0, 1'b1, SZ_H, 1'b0, 13'h22, 64'h1234);
        req(1'b0, 1'b0, SZ_H, 1'b0, 13'h22, 64'h0);
        checks++;
        if (r_err !== 1'b0 || r_data !== 64'h00001234) begin
            failures++;
            $display("FAIL ld_half got=%h exp=00001234", r_data);
        end
        if32.dbg_addr = 4'd8;
        #1;
        checks++;
        if (if32.dbg_data !== 32'h12340000) begin
            failures++;
            $display("FAIL dbg_word8 got=%h exp=12340000", if32.dbg_data);
        end
    endtask

    task automatic test_errors();
        req(1'b0, 1'b0, SZ_H, 1'b0, 13'h21, 64'h0);
        checks++;
        if (r_err !== 1'b1 || r_data !== 64'h0) begin
            failures++;
            $display("FAIL err_half_mis got=err%b %h exp=err1 0", r_err, r_data);
        end
        req(1'b0, 1'b1, SZ_W, 1'b0, 13'h12, 64'h55667788);
        checks++;
        if (r_err !== 1'b1 || r_data !== 64'h0) begin
            failures++;
            $display("FAIL err_word_mis got=err%b %h exp=err1 0", r_err, r_data);
        end
        if32.dbg_addr = 4'd4;
        #1;
        checks++;
        if (if32.dbg_data !== 32'hF099AABB) begin
            failures++;
            $display("FAIL err_word_nowrite got=%h exp=f099aabb", if32.dbg_data);
        end
        req(1'b0, 1'b1, SZ_D, 1'b0, 13'h20, 64'hCAFE);
        checks++;
        if (r_err !== 1'b1 || r_data !== 64'h0) begin
            failures++;
            $display("FAIL err_dword32 got=err%b %h exp=err1 0", r_err, r_data);
        end
        if32.dbg_addr = 4'd8;
        #1;
        checks++;
        if (if32.dbg_data !== 32'h12340000) begin
            failures++;
            $display("FAIL err_dword_nowrite got=%h exp=12340000", if32.dbg_data);
        end
        req(1'b0, 1'b0, SZ_D, 1'b1, 13'h20, 64'h0);
        checks++;
        if (r_err !== 1'b1 || r_data !== 64'h0) begin
            failures++;
            $display("FAIL err_dword_load got=err%b %h exp=err1 0", r_err, r_data);
        end
    endtask

    task automatic test_reset_access();
        bit seen;
        req(1'b0, 1'b1, SZ_W, 1'b0, 13'h30, 64'h11223344);
        if32.dbg_addr = 4'd12;
        @(negedge clk);
        if32.req_valid = 1'b1;
        if32.req_we    = 1'b1;
        if32.req_size  = SZ_W;
        if32.req_addr  = 12'h30;
        if32.req_wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        clear_req();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                checks++;
                if (if32.req_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL rst_access_ready got=%b exp=1", if32.req_ready);
                end
            end
            if (if32.rsp_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL rst_access_rsp got=%b exp=0", seen);
        end
        checks++;
        if (if32.dbg_data !== 32'h11223344) begin
            failures++;
            $display("FAIL rst_access_mem got=%h exp=11223344", if32.dbg_data);
        end
    endtask

    task automatic test_wide();
        int pulses;
        int bad;
        req(1'b1, 1'b1, SZ_D, 1'b0, 13'h8, 64'h0102030405060708);
        checks++;
        if (r_err !== 1'b0 || r_lat !== 2) begin
            failures++;
            $display("FAIL st_dword got=err%b lat%0d exp=err0 lat2", r_err, r_lat);
        end
        req(1'b1, 1'b0, SZ_B, 1'b0, 13'hF, 64'h0);
        checks++;
        if (r_data !== 64'h0000000000000001) begin
            failures++;
            $display("FAIL ld_byte64 got=%h exp=0000000000000001", r_data);
        end
        req(1'b1, 1'b0, SZ_H, 1'b0, 13'hE, 64'h0);
        checks++;
        if (r_data !== 64'h0000000000000102) begin
            failures++;
            $display("FAIL ld_half64 got=%h exp=0000000000000102", r_data);
        end
        req(1'b1, 1'b0, SZ_W, 1'b0, 13'hA, 64'h0);
        checks++;
        if (r_err !== 1'b1 || r_data !== 64'h0) begin
            failures++;
            $display("FAIL err_word64_mis got=err%b %h exp=err1 0", r_err, r_data);
        end
        @(negedge clk);
        if64.req_valid    = 1'b1;
        if64.req_we       = 1'b0;
        if64.req_size     = SZ_D;
        if64.req_unsigned = 1'b0;
        if64.req_addr     = 13'h8;
        pulses = 0;
        bad    = 0;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk);
            #1;
            if (if64.rsp_valid) begin
                pulses++;
                if (if64.rsp_rdata !== 64'h0102030405060708) bad++;
            end
        end
        clear_req();
        checks++;
        if (pulses !== 3) begin
            failures++;
            $display("FAIL busy_pulses got=%0d exp=3", pulses);
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL busy_rdata got=%0d bad exp=0", bad);
        end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_reset_access();
        test_wide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
